// File: rtl/flash_sample_reader_if.sv
// ---------------------------------------------------------------------------
// flash_sample_reader_if
// Avalon-MM read-only bus between the sample reader (master) and the
// on-board flash controller (slave).
//
// Signals:
//   read           master -> slave  read request, held until accepted
//   address        master -> slave  word address
//   byteenable     master -> slave  byte lanes (always all four)
//   waitrequest    slave  -> master stall; request accepted when low
//   readdata       slave  -> master read data word
//   readdatavalid  slave  -> master one-cycle strobe qualifying readdata
// ---------------------------------------------------------------------------
interface flash_sample_reader_if #(
    parameter int ADDR_W = 23,
    parameter int DATA_W = 32
);
    logic              read;
    logic [ADDR_W-1:0] address;
    logic [3:0]        byteenable;
    logic              waitrequest;
    logic [DATA_W-1:0] readdata;
    logic              readdatavalid;

    modport master (
        output read,
        output address,
        output byteenable,
        input  waitrequest,
        input  readdata,
        input  readdatavalid
    );

    modport slave (
        input  read,
        input  address,
        input  byteenable,
        output waitrequest,
        output readdata,
        output readdatavalid
    );
endinterface

// File: rtl/flash_sample_reader.sv
// ---------------------------------------------------------------------------
// flash_sample_reader
// Fetches one 32-bit word from flash per request from the playback address
// FSM and plays it out as two signed 16-bit samples on successive sample
// ticks. Forward playback emits the low half first, backward the high half.
//
// Ports:
//   clk, reset    system clock, synchronous active-high reset
//   set_clk       asynchronous sample-rate clock; each rising edge is a tick
//   read          single-cycle fetch request
//   addr          word address qualified by read
//   backward      playback direction qualified by read
//   vol_shift     (FLASH_SAMPLE_VOLUME_EN only) arithmetic right shift
//                 applied to each sample as it is emitted
//   flash_mem     Avalon-MM read master port
//   audio_sample  current sample, held between updates
//   sample_valid  one-cycle pulse when audio_sample updates
//   busy          high whenever a fetch/playout is in progress
//
// Build option: define FLASH_SAMPLE_VOLUME_EN to add the vol_shift input.
// DATA_W must equal 2*SAMPLE_W.
// ---------------------------------------------------------------------------
module flash_sample_reader #(
    parameter int ADDR_W      = 23,
    parameter int DATA_W      = 32,
    parameter int SAMPLE_W    = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       set_clk,
    input  logic                       read,
    input  logic [ADDR_W-1:0]          addr,
    input  logic                       backward,
`ifdef FLASH_SAMPLE_VOLUME_EN
    input  logic [2:0]                 vol_shift,
`endif
    flash_sample_reader_if.master      flash_mem,
    output logic signed [SAMPLE_W-1:0] audio_sample,
    output logic                       sample_valid,
    output logic                       busy
);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT_DATA,
        FIRST,
        SECOND
    } state_t;

    function automatic logic signed [SAMPLE_W-1:0] scale_sample(
        input logic signed [SAMPLE_W-1:0] s,
        input logic [2:0]                 sh
    );
        return s >>> sh;
    endfunction

    logic [2:0] shift_amt;
`ifdef FLASH_SAMPLE_VOLUME_EN
    assign shift_amt = vol_shift;
`else
    assign shift_amt = 3'd0;
`endif

    // ---- stage p0/p1: set_clk synchronizer and edge register ----
    logic [SYNC_STAGES-1:0] set_clk_p0;
    logic                   set_clk_p1;
    logic                   tick_p2;

    always_ff @(posedge clk) begin
        if (reset) begin
            set_clk_p0 <= '0;
            set_clk_p1 <= 1'b0;
            tick_p2    <= 1'b0;
        end else begin
            set_clk_p0[0] <= set_clk;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                set_clk_p0[i] <= set_clk_p0[i-1];
            end
            set_clk_p1 <= set_clk_p0[SYNC_STAGES-1];
            // ---- stage p2: registered rising-edge tick ----
            tick_p2    <= set_clk_p0[SYNC_STAGES-1] & ~set_clk_p1;
        end
    end

    // ---- control state ----
    state_t                      state, state_n;
    logic                        pending, pending_n;
    logic                        mem_read, mem_read_n;
    logic [ADDR_W-1:0]           mem_addr, mem_addr_n;
    logic signed [SAMPLE_W-1:0]  sample_n;
    logic                        valid_n;

    // ---- data registers (no reset: always written before being used) ----
    logic [DATA_W-1:0]           word;
    logic                        cur_bwd;
    logic [ADDR_W-1:0]           pend_addr;
    logic                        pend_bwd;

    logic                        take_req;
    logic                        pend_load;
    logic                        capture;

    logic signed [SAMPLE_W-1:0]  lo_half;
    logic signed [SAMPLE_W-1:0]  hi_half;

    assign lo_half = $signed(word[SAMPLE_W-1:0]);
    assign hi_half = $signed(word[DATA_W-1:SAMPLE_W]);

    always_comb begin
        state_n    = state;
        pending_n  = pending;
        mem_read_n = mem_read;
        mem_addr_n = mem_addr;
        sample_n   = audio_sample;
        valid_n    = 1'b0;
        take_req   = 1'b0;
        pend_load  = 1'b0;
        capture    = 1'b0;

        case (state)
            IDLE: begin
                // A fresh read is newer than anything pending, so it wins.
                if (read || pending) begin
                    take_req   = 1'b1;
                    pending_n  = 1'b0;
                    mem_read_n = 1'b1;
                    mem_addr_n = read ? addr : pend_addr;
                    state_n    = REQ;
                end
            end
            REQ: begin
                if (!flash_mem.waitrequest) begin
                    mem_read_n = 1'b0;
                    state_n    = WAIT_DATA;
                end
            end
            WAIT_DATA: begin
                if (flash_mem.readdatavalid) begin
                    capture = 1'b1;
                    state_n = FIRST;
                end
            end
            FIRST: begin
                if (tick_p2) begin
                    sample_n = scale_sample(cur_bwd ? hi_half : lo_half, shift_amt);
                    valid_n  = 1'b1;
                    state_n  = SECOND;
                end
            end
            SECOND: begin
                if (tick_p2) begin
                    sample_n = scale_sample(cur_bwd ? lo_half : hi_half, shift_amt);
                    valid_n  = 1'b1;
                    state_n  = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        // A request arriving mid-transaction is remembered one deep, last wins.
        if (state != IDLE && read) begin
            pending_n = 1'b1;
            pend_load = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            pending      <= 1'b0;
            mem_read     <= 1'b0;
            mem_addr     <= '0;
            audio_sample <= '0;
            sample_valid <= 1'b0;
        end else begin
            state        <= state_n;
            pending      <= pending_n;
            mem_read     <= mem_read_n;
            mem_addr     <= mem_addr_n;
            audio_sample <= sample_n;
            sample_valid <= valid_n;
        end
    end

    always_ff @(posedge clk) begin
        if (take_req) begin
            cur_bwd <= read ? backward : pend_bwd;
        end
        if (pend_load) begin
            pend_addr <= addr;
            pend_bwd  <= backward;
        end
        if (capture) begin
            word <= flash_mem.readdata;
        end
    end

    assign flash_mem.read       = mem_read;
    assign flash_mem.address    = mem_addr;
    assign flash_mem.byteenable = 4'b1111;
    assign busy                 = (state != IDLE);

endmodule

// File: doc/flash_sample_reader.md
Name: flash_sample_reader

Overview:
- Downstream of the playback address FSM. It consumes that FSM's read strobe and 23-bit word address.
- Fetches the 32-bit word from on-board flash over an Avalon-MM read master with waitrequest and readdatavalid.
- Splits each word into two signed 16-bit audio samples. The halves are presented to the audio codec path on successive sample ticks, in an order set by playback direction.

Parameters:
- ADDR_W, 23, flash word address width.
- DATA_W, 32, flash read data width.
- SAMPLE_W, 16, audio sample width; DATA_W = 2*SAMPLE_W required.
- SYNC_STAGES, 2, synchronizer depth on set_clk before edge detect.

Ports:
- clk  input  1  system clock, 50 MHz.
- reset  input  1  synchronous, active-high.
- set_clk  input  1  sample-rate clock from speed control (~22 kHz, asynchronous level).
- read  input  1  single-cycle fetch request from the address FSM.
- addr  input  ADDR_W  word address, valid while read=1.
- backward  input  1  0 = forward (low half first), 1 = backward (high half first); sampled with read.
- flash_mem_read  output  1  Avalon read request.
- flash_mem_address  output  ADDR_W  Avalon word address.
- flash_mem_byteenable  output  4  constant 4'b1111.
- flash_mem_waitrequest  input  1  Avalon stall.
- flash_mem_readdata  input  DATA_W  Avalon read data.
- flash_mem_readdatavalid  input  1  Avalon data-valid strobe.
- audio_sample  output  SAMPLE_W  current signed sample, held between updates.
- sample_valid  output  1  one-cycle pulse when audio_sample changes.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset values:
  - flash_mem_read=0, flash_mem_address=0, audio_sample=0.
  - sample_valid=0, busy=0, pending flag=0, state=IDLE.
- set_clk handling: pass through SYNC_STAGES flops, then rising-edge detect. A tick is a 1-clk pulse, 1 per set_clk period, latency SYNC_STAGES+1 clks.
- FSM states: IDLE, REQ, WAIT_DATA, FIRST, SECOND.
- IDLE:
  - On read=1 (or pending=1), latch addr and backward, clear pending, go to REQ.
  - The next cycle drives flash_mem_read=1 and flash_mem_address.
- REQ:
  - Hold flash_mem_read and flash_mem_address stable while waitrequest=1.
  - On the first clk with waitrequest=0, deassert flash_mem_read next cycle and go to WAIT_DATA.
- WAIT_DATA:
  - On readdatavalid=1, capture readdata into a word register and go to FIRST.
  - No timeout.
- FIRST: on the next tick, drive audio_sample and pulse sample_valid, then go to SECOND.
  - Forward: audio_sample = word[15:0].
  - Backward: audio_sample = word[31:16].
- SECOND: on the next tick, output the other half, pulse sample_valid, go to IDLE.
- Output timing: audio_sample updates on the same clk as sample_valid and holds until the next update.
- Read while busy:
  - Sets pending=1 and overwrites the latched pending addr/backward, so the last request wins. One-deep only.
  - Pending is served on the IDLE entry cycle, with no extra idle clk.
- Read and SECOND-tick in the same clk: the second sample is emitted and the read is captured as pending. Both actions happen.
- Ticks in IDLE, REQ or WAIT_DATA are ignored. audio_sample holds its last value, so no underflow glitch.
- readdatavalid seen outside WAIT_DATA (for example a response arriving after reset) is discarded.
- Reset mid-transaction:
  - Drops flash_mem_read on the next edge and returns to IDLE.
  - Clears pending and zeroes audio_sample.
- Address arithmetic: none. addr is passed through unmodified; wrap-around is the address FSM's responsibility.

Optional Feature:
- Macro: FLASH_SAMPLE_VOLUME_EN.
- Defined:
  - Adds input port vol_shift [2:0].
  - Each half is arithmetically right-shifted (sign-preserving) by vol_shift before driving audio_sample.
  - vol_shift is sampled on the emit clk.
  - vol_shift=0 gives an identical result to undefined.
- Undefined: no vol_shift port; halves are output unmodified.

Test Plan:
- Forward fetch:
  - Stimulus: read with addr=23'h000010, backward=0; waitrequest high 3 clks; readdata=32'hBEEF_1234 after 2 clks.
  - Response: flash_mem_address=23'h000010 held 4 clks; audio_sample=16'h1234 on tick 1, then 16'hBEEF on tick 2; 2 sample_valid pulses; busy falls after tick 2.
- Backward fetch:
  - Stimulus: same word with backward=1.
  - Response: 16'hBEEF first, then 16'h1234.
- Back-to-back requests:
  - Stimulus: read addr=5 during WAIT_DATA of addr=4, then read addr=6 before SECOND.
  - Response: only addr 4 and addr 6 are issued on flash_mem_address; addr 5 never appears.
- Reset in WAIT_DATA:
  - Stimulus: assert reset 1 clk, then a stray readdatavalid with 32'hFFFF_FFFF.
  - Response: flash_mem_read=0, busy=0, audio_sample stays 0, no sample_valid.
- Stall robustness:
  - Stimulus: waitrequest held high 40 clks.
  - Response: address/read stable throughout; ticks in that window produce no sample_valid.
- Volume (FLASH_SAMPLE_VOLUME_EN):
  - Stimulus: vol_shift=2, word=32'h8000_0400, forward.
  - Response: 16'h0100, then 16'hE000.
